// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and RAM signals around the
// unified memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic [31:0]       ic_rdata;
  logic              ic_ack;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [31:0]       dc_wdata;
  logic [31:0]       dc_rdata;
  logic              dc_ack;

  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_ready;

  logic              if_stall;
  logic              mem_stall;
  logic              timeout_err;

  modport slave (
    input  ic_req,
    input  ic_addr,
    output ic_rdata,
    output ic_ack,
    input  dc_req,
    input  dc_we,
    input  dc_addr,
    input  dc_wdata,
    output dc_rdata,
    output dc_ack,
    output ram_cs,
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata,
    input  ram_ready,
    output if_stall,
    output mem_stall,
    output timeout_err
  );

  modport master (
    output ic_req,
    output ic_addr,
    input  ic_rdata,
    input  ic_ack,
    output dc_req,
    output dc_we,
    output dc_addr,
    output dc_wdata,
    input  dc_rdata,
    input  dc_ack,
    input  ram_cs,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata,
    output ram_ready,
    input  if_stall,
    input  mem_stall,
    input  timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and MEM load/store port onto
// one variable-latency RAM, with starvation cap and timeout.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input logic            clk,
  input logic            rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1) < 1 ?
                      1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);
  localparam logic [15:0]   W_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    INST,
    DATA
  } state_t;

  state_t            state;
  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              ic_ack;
  logic              dc_ack;
  logic [31:0]       ic_rdata;
  logic [31:0]       dc_rdata;
  logic              timeout_err;
  logic [SW-1:0]     starve_cnt;
  logic [15:0]       wait_cnt;

  logic ic_cand;
  logic dc_cand;
  logic pick_dc;
  logic pick_ic;

  // A port in its ack cycle is masked so it is not regranted.
  always_comb begin
    ic_cand = bus.ic_req & ~ic_ack;
    dc_cand = bus.dc_req & ~dc_ack;
    pick_dc = dc_cand &
              ~(ic_cand & (starve_cnt == S_MAX));
    pick_ic = ic_cand & ~pick_dc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ic_ack      <= 1'b0;
      dc_ack      <= 1'b0;
      ic_rdata    <= '0;
      dc_rdata    <= '0;
      timeout_err <= 1'b0;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
    end else begin
      ic_ack <= 1'b0;
      dc_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            pick_dc: begin
              state     <= DATA;
              ram_cs    <= 1'b1;
              ram_we    <= bus.dc_we;
              ram_addr  <= bus.dc_addr;
              ram_wdata <= bus.dc_wdata;
              wait_cnt  <= '0;
              starve_cnt <= ic_cand ?
                            starve_cnt + 1'b1 : '0;
            end
            pick_ic: begin
              state      <= INST;
              ram_cs     <= 1'b1;
              ram_we     <= 1'b0;
              ram_addr   <= bus.ic_addr;
              ram_wdata  <= '0;
              wait_cnt   <= '0;
              starve_cnt <= '0;
            end
            default: ;
          endcase
        end
        INST, DATA: begin
          if (bus.ram_ready) begin
            state  <= IDLE;
            ram_cs <= 1'b0;
            if (state == INST) begin
              ic_rdata <= bus.ram_rdata;
              ic_ack   <= 1'b1;
            end else begin
              dc_rdata <= bus.ram_rdata;
              dc_ack   <= 1'b1;
            end
          end else if (wait_cnt == W_LAST) begin
            // Abort: ack with zero data and flag it.
            state       <= IDLE;
            ram_cs      <= 1'b0;
            timeout_err <= 1'b1;
            if (state == INST) begin
              ic_rdata <= '0;
              ic_ack   <= 1'b1;
            end else begin
              dc_rdata <= '0;
              dc_ack   <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_cs      = ram_cs;
  assign bus.ram_we      = ram_we;
  assign bus.ram_addr    = ram_addr;
  assign bus.ram_wdata   = ram_wdata;
  assign bus.ic_ack      = ic_ack;
  assign bus.dc_ack      = dc_ack;
  assign bus.ic_rdata    = ic_rdata;
  assign bus.dc_rdata    = dc_rdata;
  assign bus.timeout_err = timeout_err;
  assign bus.if_stall    = bus.ic_req & ~ic_ack;
  assign bus.mem_stall   = bus.dc_req & ~dc_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, grant/ack
// scoreboard and hand-written multi-cycle sequences.
module tb_mem_port_arbiter;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW),
    .STARVE_MAX(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_model(
    input logic [31:0] a);
    if (a == 32'h40) return 32'h2008_000A;
    return a ^ 32'h5A5A_0000;
  endfunction

  // RAM responder: ready after lat wait cycles unless hung.
  int lat = 0;
  bit hang = 1'b0;
  int cs_cycles = 0;
  assign bus.ram_rdata = ram_model(bus.ram_addr);
  assign bus.ram_ready = bus.ram_cs && !hang &&
                         (cs_cycles == lat);
  always @(posedge clk)
    cs_cycles <= (bus.ram_cs && !bus.ram_ready) ?
                 cs_cycles + 1 : 0;

  typedef struct {
    logic        dc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t gq[$];
  exp_t aq[$];

  task automatic push(input exp_t e);
    gq.push_back(e);
    aq.push_back(e);
  endtask

  logic        prev_cs   = 1'b0;
  logic        prev_we   = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    exp_t e;
    if (bus.ram_cs && !prev_cs) begin
      if (gq.size() == 0) begin
        chk("grant_unexpected", bus.ram_addr, 32'hFFFF_FFFF);
      end else begin
        e = gq.pop_front();
        chk("grant_addr", bus.ram_addr, e.addr);
        chk("grant_we", 32'(bus.ram_we), 32'(e.we));
        if (e.we) chk("grant_wdata", bus.ram_wdata, e.wdata);
      end
    end else if (bus.ram_cs) begin
      chk("hold_addr", bus.ram_addr, prev_addr);
      chk("hold_we", 32'(bus.ram_we), 32'(prev_we));
    end
    if (bus.ic_ack || bus.dc_ack) begin
      chk("one_ack", 32'(bus.ic_ack & bus.dc_ack), 32'd0);
      if (aq.size() == 0) begin
        chk("ack_unexpected", 32'd1, 32'd0);
      end else begin
        e = aq.pop_front();
        chk("ack_port", 32'(bus.dc_ack), 32'(e.dc));
        chk("ack_rdata",
            bus.dc_ack ? bus.dc_rdata : bus.ic_rdata,
            e.rdata);
      end
    end
    prev_cs   <= bus.ram_cs;
    prev_we   <= bus.ram_we;
    prev_addr <= bus.ram_addr;
  end

  typedef struct {
    logic        dc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          hang;
    int          cyc;
    logic [31:0] rdata;
    logic        tmo;
  } vec_t;

  vec_t vt[7];

  task automatic run_vec(input vec_t v);
    int   k;
    logic stall_ok;
    exp_t e;
    lat  = v.lat;
    hang = v.hang;
    e = '{v.dc, v.we, v.addr, v.wdata, v.rdata};
    push(e);
    if (v.dc) begin
      bus.dc_we    = v.we;
      bus.dc_addr  = v.addr;
      bus.dc_wdata = v.wdata;
      bus.dc_req   = 1'b1;
    end else begin
      bus.ic_addr = v.addr;
      bus.ic_req  = 1'b1;
    end
    k = 0;
    stall_ok = 1'b1;
    while (k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.ic_ack || bus.dc_ack) break;
      stall_ok &= v.dc ? bus.mem_stall : bus.if_stall;
    end
    chk("vec_latency", 32'(k), 32'(v.cyc));
    chk("vec_stall_wait", 32'(stall_ok), 32'd1);
    chk("vec_stall_ack",
        32'(v.dc ? bus.mem_stall : bus.if_stall), 32'd0);
    chk("vec_tmo", 32'(bus.timeout_err), 32'(v.tmo));
    bus.ic_req = 1'b0;
    bus.dc_req = 1'b0;
    hang = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int   k;
    int   kd;
    int   ki;
    int   dn;
    bit   idone;
    exp_t e;

    vt[0] = '{1'b0, 1'b0, 32'h40,  32'h0, 0, 1'b0, 2,
              32'h2008_000A, 1'b0};
    vt[1] = '{1'b1, 1'b0, 32'h44,  32'h0, 0, 1'b0, 2,
              32'h5A5A_0044, 1'b0};
    vt[2] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3, 1'b0, 5,
              32'h5A5A_0100, 1'b0};
    vt[3] = '{1'b0, 1'b0, 32'h48,  32'h0, 1, 1'b0, 3,
              32'h5A5A_0048, 1'b0};
    vt[4] = '{1'b1, 1'b0, 32'h60,  32'h0, 0, 1'b1, 9,
              32'h0, 1'b1};
    vt[5] = '{1'b0, 1'b0, 32'h4C,  32'h0, 0, 1'b0, 2,
              32'h5A5A_004C, 1'b1};
    vt[6] = '{1'b1, 1'b0, 32'h64,  32'h0, 2, 1'b0, 4,
              32'h5A5A_0064, 1'b1};

    bus.ic_req   = 1'b0;
    bus.ic_addr  = '0;
    bus.dc_req   = 1'b0;
    bus.dc_we    = 1'b0;
    bus.dc_addr  = '0;
    bus.dc_wdata = '0;

    @(negedge clk);
    chk("rst_ram_cs", 32'(bus.ram_cs), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ram_addr", bus.ram_addr, 32'd0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'd0);
    chk("rst_acks", 32'({bus.ic_ack, bus.dc_ack}), 32'd0);
    chk("rst_ic_rdata", bus.ic_rdata, 32'd0);
    chk("rst_dc_rdata", bus.dc_rdata, 32'd0);
    chk("rst_tmo", 32'(bus.timeout_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vt[i]) run_vec(vt[i]);

    // Simultaneous store and fetch: data first, fetch in ack cycle.
    lat  = 0;
    hang = 1'b0;
    e = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h5A5A_0100};
    push(e);
    e = '{1'b0, 1'b0, 32'h80, 32'h0, 32'h5A5A_0080};
    push(e);
    bus.ic_addr  = 32'h80;
    bus.dc_we    = 1'b1;
    bus.dc_addr  = 32'h100;
    bus.dc_wdata = 32'hDEAD_BEEF;
    bus.ic_req   = 1'b1;
    bus.dc_req   = 1'b1;
    k  = 0;
    kd = -1;
    ki = -1;
    while (k < 40 && ki < 0) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.dc_ack) begin
        kd = k;
        chk("both_memstall_ack", 32'(bus.mem_stall), 32'd0);
        chk("both_ifstall", 32'(bus.if_stall), 32'd1);
        bus.dc_req = 1'b0;
      end
      if (bus.ic_ack) begin
        ki = k;
        bus.ic_req = 1'b0;
      end
    end
    chk("both_dc_first", 32'(kd), 32'd2);
    chk("both_ic_gap", 32'(ki - kd), 32'd2);
    @(posedge clk);
    #1;

    // Fetch pending between data acks: cap after four data grants.
    for (int i = 0; i < 4; i++) begin
      e = '{1'b1, 1'b0, 32'(32'h300 + 4 * i), 32'h0,
            ram_model(32'(32'h300 + 4 * i))};
      push(e);
    end
    e = '{1'b0, 1'b0, 32'h200, 32'h0, ram_model(32'h200)};
    push(e);
    for (int i = 4; i < 6; i++) begin
      e = '{1'b1, 1'b0, 32'(32'h300 + 4 * i), 32'h0,
            ram_model(32'(32'h300 + 4 * i))};
      push(e);
    end
    bus.dc_we   = 1'b0;
    bus.dc_addr = 32'h300;
    bus.ic_addr = 32'h200;
    bus.dc_req  = 1'b1;
    bus.ic_req  = 1'b1;
    dn    = 0;
    idone = 1'b0;
    k     = 0;
    while (k < 100 && !(dn == 6 && idone)) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.dc_ack) begin
        dn++;
        if (dn == 6) bus.dc_req = 1'b0;
        else bus.dc_addr = 32'(32'h300 + 4 * dn);
      end
      if (bus.ic_ack) begin
        idone = 1'b1;
        bus.ic_req = 1'b0;
      end else if (!idone) begin
        bus.ic_req = !bus.dc_ack;
      end
    end
    chk("fair_done", 32'(dn == 6 && idone), 32'd1);
    bus.dc_req = 1'b0;
    bus.ic_req = 1'b0;
    @(posedge clk);
    #1;

    // Reset during a DATA wait, then re-arbitration.
    hang = 1'b1;
    e = '{1'b1, 1'b0, 32'h70, 32'h0, 32'h5A5A_0070};
    push(e);
    bus.dc_we   = 1'b0;
    bus.dc_addr = 32'h70;
    bus.dc_req  = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    chk("tmo_sticky_pre", 32'(bus.timeout_err), 32'd1);
    chk("wait_cs_pre", 32'(bus.ram_cs), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_cs", 32'(bus.ram_cs), 32'd0);
    chk("arst_dc_ack", 32'(bus.dc_ack), 32'd0);
    chk("arst_tmo", 32'(bus.timeout_err), 32'd0);
    gq.push_back(e);
    hang = 1'b0;
    lat  = 0;
    @(posedge clk);
    #1;
    chk("arst_hold_cs", 32'(bus.ram_cs), 32'd0);
    rst = 1'b1;
    k = 0;
    while (k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.dc_ack) break;
    end
    chk("rst_regrant_lat", 32'(k), 32'd2);
    bus.dc_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    chk("sb_empty", 32'(gq.size() + aq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data RAM between the IF stage fetch port and the MEM stage load/store port of the 5-stage MIPS pipeline.
- Grants one access at a time and sequences it through a ready-handshaked RAM of variable latency.
- Returns read data and one-cycle acks to each port.
- Produces if_stall and mem_stall, which the pipeline controller uses to freeze stages.

Parameters:
- ADDR_W, 32, byte address width on all ports.
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending.
- TIMEOUT, 255, RAM wait cycles before an access is aborted. Must be ≥ 1 and < 2^16.

Ports:
- clk  in  1  main clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ic_req  in  1  fetch request; held until ic_ack.
- ic_addr  in  ADDR_W  fetch address.
- ic_rdata  out  32  fetch data; valid while ic_ack=1.
- ic_ack  out  1  one-cycle fetch completion pulse.
- dc_req  in  1  data request; held until dc_ack.
- dc_we  in  1  1 = store, 0 = load.
- dc_addr  in  ADDR_W  data address.
- dc_wdata  in  32  store data.
- dc_rdata  out  32  load data; valid while dc_ack=1.
- dc_ack  out  1  one-cycle data completion pulse.
- ram_cs  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data; valid with ram_ready.
- ram_ready  in  1  RAM completes the current access this cycle.
- if_stall  out  1  ic_req & ~ic_ack, combinational.
- mem_stall  out  1  dc_req & ~dc_ack, combinational.
- timeout_err  out  1  sticky flag; set on any aborted access.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All registered outputs = 0: ram_cs, ram_we, ram_addr, ram_wdata, ic_ack, dc_ack, ic_rdata, dc_rdata, timeout_err.
  - starve_cnt=0, wait_cnt=0.
  - Reset mid-access abandons the access; no ack is issued.
- State IDLE:
  - Candidate port = its req=1 and its ack is not high this cycle. The port being acked is masked, so it cannot be regranted in its own ack cycle.
  - Grant selection:
    - Data port if it is a candidate and not (ic candidate and starve_cnt==STARVE_MAX).
    - Otherwise the fetch port if it is a candidate.
    - Otherwise remain in IDLE.
  - On grant, register the selected port's addr/we/wdata into ram_addr/ram_we/ram_wdata. A fetch grant forces we=0. Set ram_cs=1 and wait_cnt=0. Go to DATA or INST.
  - starve_cnt update:
    - Data grant while ic is a candidate: increment.
    - Fetch grant: clear to 0.
    - Data grant with no fetch pending: clear to 0.
- States INST / DATA:
  - ram_cs, ram_we, ram_addr and ram_wdata are held stable.
  - If ram_ready=1:
    - Register ram_rdata into the granted port's rdata.
    - Pulse that port's ack for exactly the next cycle.
    - ram_cs=0, go to IDLE.
    - For stores, rdata is loaded with ram_rdata (don't-care contents).
  - Otherwise wait_cnt++. When wait_cnt reaches TIMEOUT with ram_ready still 0:
    - Abort: ack the port with rdata=0, set timeout_err=1, ram_cs=0, go to IDLE.
- Latency:
  - Minimum, request in IDLE at cycle N: ram_cs=1 at N+1, ram_ready at N+1, ack at N+2.
  - Back-to-back accesses: the other port can be granted in the ack cycle, giving ram_cs=1 again at N+3.
- Stalls: if_stall and mem_stall drop in the ack cycle so the pipeline advances exactly once per ack.
- A requester changing addr while req=1 before its ack is illegal and is not checked. The granted values are the ones sampled at grant.
- timeout_err is cleared only by reset.
- Only one ack is asserted in any cycle.

Test Plan:
- Single fetch, ram_ready tied to 1, ic_addr=0x40, ram_rdata=0x2008000A -> ram_cs=1 with addr 0x40 at cycle 1; ic_ack=1 with ic_rdata=0x2008000A at cycle 2; if_stall=0 at cycle 2; no other acks.
- ic_req and dc_req (store, addr 0x100, wdata 0xDEADBEEF) raised in the same cycle -> data granted first (ram_we=1, ram_addr=0x100); fetch granted in the dc_ack cycle; ic_ack follows 2 cycles later.
- Fairness: dc_req held high with 6 back-to-back loads while ic_req is held, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D.
- Variable latency, ram_ready asserted 3 cycles after ram_cs -> ram_addr/ram_we stable throughout; dc_ack arrives exactly 1 cycle after ram_ready; mem_stall=1 until the ack cycle.
- Timeout, TIMEOUT=8, ram_ready held at 0 -> after 8 wait cycles the port is acked with rdata=0, timeout_err=1 stays set, and the next request proceeds normally.
- rst pulled low during a DATA wait -> ram_cs, acks and timeout_err are 0 immediately (asynchronous); no ack follows release; the pending request is re-arbitrated from IDLE.
